// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the LDM/STM micro-sequencer.
// Contents: default widths, {P,U} addressing-mode encoding, FSM state
// encoding and the PC register index.
package ldm_stm_seq_pkg;

    localparam int unsigned NREG_DEF = 16;
    localparam int unsigned AW_DEF   = 32;
    localparam int unsigned RIDX_W   = 4;

    // Addressing mode is the concatenation {P,U}
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } amode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_e;

    localparam logic [RIDX_W-1:0] PC_IDX = 4'd15;

endpackage

// File: rtl/ldm_stm_seq_prio_enc16.sv
// prio_enc16: lowest-set-bit priority encoder for a 16-bit register mask.
// Ports:
//   mask - register mask
//   idx  - index of the lowest set bit (0 when mask is empty)
//   one  - exactly one bit of mask is set
module ldm_stm_seq_prio_enc16
    import ldm_stm_seq_pkg::*;
(
    input  logic [15:0]       mask,
    output logic [RIDX_W-1:0] idx,
    output logic              one
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin : lsb_scan
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = RIDX_W'(i);
            end
        end
    end

    // Clearing the lowest bit leaves zero only for a single-bit mask
    assign one = (mask != 16'd0) && ((mask & (mask - 16'd1)) == 16'd0);

endmodule

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: decode-stage micro-sequencer expanding one LDM/STM into one
// transfer micro-op per listed register, plus base-register writeback.
// Ports:
//   clk, reset (async, active-low)
//   start/is_load/pre/up/wback/reglist/base_rn/base_val - decoded instruction
//   stall        - downstream not ready; freezes all state and outputs
//   start_ready  - instruction accepted this cycle (combinational on stall)
//   busy         - instruction in progress, front end must stall
//   uop_*        - registered transfer micro-op (reg, addr, load, last, pc)
//   wb_we/wa/wd  - base writeback onto regfile port 1
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre,
    input  logic              up,
    input  logic              wback,
    input  logic [NREG-1:0]   reglist,
    input  logic [RIDX_W-1:0] base_rn,
    input  logic [AW-1:0]     base_val,
    input  logic              stall,
    output logic              start_ready,
    output logic              busy,
    output logic              uop_valid,
    output logic [RIDX_W-1:0] uop_reg,
    output logic [AW-1:0]     uop_addr,
    output logic              uop_load,
    output logic              uop_last,
    output logic              uop_pc,
    output logic              wb_we,
    output logic [RIDX_W-1:0] wb_wa,
    output logic [AW-1:0]     wb_wd
);

    localparam int unsigned CNT_W = $clog2(NREG + 1);

    state_e              state_q, state_d;
    logic [NREG-1:0]     list_q, list_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       nb_q, nb_d;
    logic                load_q, load_d;
    logic [RIDX_W-1:0]   rn_q, rn_d;
    logic                wback_q, wback_d;
    logic                inlist_q, inlist_d;

    logic                busy_d, uop_valid_d, uop_load_d, uop_last_d, uop_pc_d, wb_we_d;
    logic [RIDX_W-1:0]   uop_reg_d, wb_wa_d;
    logic [AW-1:0]       uop_addr_d, wb_wd_d;

    logic [CNT_W-1:0]    cnt;
    logic [AW-1:0]       four_n, a0_raw, a0, new_base;
    logic [AW-1:0]       cur_addr;
    logic [NREG-1:0]     src_list;
    logic [RIDX_W-1:0]   enc_idx;
    logic                enc_one;
    logic                accept, emit;

    assign start_ready = (state_q == S_IDLE) && !stall;
    assign accept      = start_ready && start;

    // Transfer count, first (lowest) address and updated base for a new instruction
    always_comb begin : addr_calc
        cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + CNT_W'(reglist[i]);
        end
        four_n = AW'(cnt) << 2;
        case (amode_e'({pre, up}))
            MODE_IA: a0_raw = base_val;
            MODE_IB: a0_raw = base_val + AW'(4);
            MODE_DA: a0_raw = base_val - four_n + AW'(4);
            default: a0_raw = base_val - four_n;
        endcase
        a0       = a0_raw & ~AW'(3);
        new_base = up ? (base_val + four_n) : (base_val - four_n);
    end

    // In IDLE the first micro-op comes straight from the incoming instruction
    assign src_list = (state_q == S_IDLE) ? reglist : list_q;
    assign cur_addr = (state_q == S_IDLE) ? a0 : addr_q;

    ldm_stm_seq_prio_enc16 u_enc (
        .mask (16'(src_list)),
        .idx  (enc_idx),
        .one  (enc_one)
    );

    // Next-state and next-output logic; everything holds by default (stall)
    always_comb begin : next_state
        state_d     = state_q;
        list_d      = list_q;
        addr_d      = addr_q;
        nb_d        = nb_q;
        load_d      = load_q;
        rn_d        = rn_q;
        wback_d     = wback_q;
        inlist_d    = inlist_q;
        busy_d      = busy;
        uop_valid_d = uop_valid;
        uop_reg_d   = uop_reg;
        uop_addr_d  = uop_addr;
        uop_load_d  = uop_load;
        uop_last_d  = uop_last;
        uop_pc_d    = uop_pc;
        wb_we_d     = wb_we;
        wb_wa_d     = wb_wa;
        wb_wd_d     = wb_wd;
        emit        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // An empty list is accepted but produces nothing
                if (accept && (reglist != '0)) begin
                    state_d  = S_XFER;
                    load_d   = is_load;
                    rn_d     = base_rn;
                    wback_d  = wback;
                    inlist_d = reglist[base_rn];
                    nb_d     = new_base;
                    emit     = 1'b1;
                end
            end
            S_XFER: begin
                if (!stall) begin
                    if (uop_last) begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        uop_valid_d = 1'b0;
                        uop_reg_d   = '0;
                        uop_addr_d  = '0;
                        uop_load_d  = 1'b0;
                        uop_last_d  = 1'b0;
                        uop_pc_d    = 1'b0;
                        wb_we_d     = 1'b0;
                        wb_wa_d     = '0;
                        wb_wd_d     = '0;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Present the lowest remaining register at the next address
        if (emit) begin
            busy_d      = 1'b1;
            uop_valid_d = 1'b1;
            uop_reg_d   = enc_idx;
            uop_addr_d  = cur_addr;
            uop_load_d  = load_d;
            uop_last_d  = enc_one;
            uop_pc_d    = load_d && (enc_idx == PC_IDX);
            // A load of the base register takes precedence over writeback
            wb_we_d     = enc_one && wback_d && !(load_d && inlist_d);
            wb_wa_d     = wb_we_d ? rn_d : '0;
            wb_wd_d     = wb_we_d ? nb_d : '0;
            list_d      = src_list & ~(NREG'(1) << enc_idx);
            addr_d      = cur_addr + AW'(4);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin : regs
        if (!reset) begin
            state_q   <= S_IDLE;
            list_q    <= '0;
            addr_q    <= '0;
            nb_q      <= '0;
            load_q    <= 1'b0;
            rn_q      <= '0;
            wback_q   <= 1'b0;
            inlist_q  <= 1'b0;
            busy      <= 1'b0;
            uop_valid <= 1'b0;
            uop_reg   <= '0;
            uop_addr  <= '0;
            uop_load  <= 1'b0;
            uop_last  <= 1'b0;
            uop_pc    <= 1'b0;
            wb_we     <= 1'b0;
            wb_wa     <= '0;
            wb_wd     <= '0;
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            addr_q    <= addr_d;
            nb_q      <= nb_d;
            load_q    <= load_d;
            rn_q      <= rn_d;
            wback_q   <= wback_d;
            inlist_q  <= inlist_d;
            busy      <= busy_d;
            uop_valid <= uop_valid_d;
            uop_reg   <= uop_reg_d;
            uop_addr  <= uop_addr_d;
            uop_load  <= uop_load_d;
            uop_last  <= uop_last_d;
            uop_pc    <= uop_pc_d;
            wb_we     <= wb_we_d;
            wb_wa     <= wb_wa_d;
            wb_wd     <= wb_wd_d;
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed block transfers followed by
// randomized instructions with random stalls, checked against a list-level
// reference model (sorted register list, contiguous word addresses).
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, is_load = 1'b0, pre = 1'b0, up = 1'b0, wback = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] reglist = '0;
    logic [3:0]  base_rn = '0;
    logic [31:0] base_val = '0;

    logic        start_ready, busy, uop_valid, uop_load, uop_last, uop_pc, wb_we;
    logic [3:0]  uop_reg, wb_wa;
    logic [31:0] uop_addr, wb_wd;

    int checks = 0;
    int failures = 0;
    int cyc_o;

    ldm_stm_seq #(.NREG(16), .AW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_load     (is_load),
        .pre         (pre),
        .up          (up),
        .wback       (wback),
        .reglist     (reglist),
        .base_rn     (base_rn),
        .base_val    (base_val),
        .stall       (stall),
        .start_ready (start_ready),
        .busy        (busy),
        .uop_valid   (uop_valid),
        .uop_reg     (uop_reg),
        .uop_addr    (uop_addr),
        .uop_load    (uop_load),
        .uop_last    (uop_last),
        .uop_pc      (uop_pc),
        .wb_we       (wb_we),
        .wb_wa       (wb_wa),
        .wb_wd       (wb_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".valid"}, 64'(uop_valid), 64'd0);
        chk({tag, ".wb_we"}, 64'(wb_we), 64'd0);
    endtask

    // Issue one instruction and follow it to completion against the model.
    // Stalls: random with stall_pct, plus a forced run of flen cycles at uop fk.
    task automatic run_instr(input string name, input bit ld, input bit p, input bit u,
                             input bit w, input logic [15:0] lst, input logic [3:0] rn,
                             input logic [31:0] base, input int stall_pct,
                             input int fk, input int flen, output int cycles);
        logic [3:0]  regs[$];
        logic [31:0] lo, nb;
        bit          exp_we, stl;
        int          n, k, held, cyc;

        // Reference: registers ascending, occupying a contiguous word block
        regs = {};
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                regs.push_back(4'(i));
                n++;
            end
        end
        nb = u ? base + 32'(4 * n) : base - 32'(4 * n);
        if (u) lo = base + (p ? 32'd4 : 32'd0);
        else if (n != 0) lo = base - (p ? 32'd4 : 32'd0) - 32'(4 * (n - 1));
        else lo = base;
        lo = lo & ~32'd3;
        exp_we = w && !(ld && lst[rn]);

        stall = 1'b0; start = 1'b1; is_load = ld; pre = p; up = u; wback = w;
        reglist = lst; base_rn = rn; base_val = base;
        #1;
        chk({name, ".ready"}, 64'(start_ready), 64'd1);
        tick();
        // Scramble the instruction inputs: they must have been latched
        is_load = 1'($urandom); pre = 1'($urandom); up = 1'($urandom);
        wback = 1'($urandom); reglist = 16'($urandom); base_rn = 4'($urandom);
        base_val = $urandom;
        start = (n != 0) ? 1'($urandom) : 1'b0;

        k = 0; held = 0; cyc = 0;
        while (k < n && cyc < 400) begin
            stl = 1'b0;
            if (k == fk && held < flen) begin
                stl = 1'b1;
                held++;
            end
            if ($urandom_range(99) < 32'(stall_pct)) stl = 1'b1;
            stall = stl;
            chk({name, ".valid"}, 64'(uop_valid), 64'd1);
            chk({name, ".busy"}, 64'(busy), 64'd1);
            chk({name, ".reg"}, 64'(uop_reg), 64'(regs[k]));
            chk({name, ".addr"}, 64'(uop_addr), 64'(lo + 32'(4 * k)));
            chk({name, ".load"}, 64'(uop_load), 64'(ld));
            chk({name, ".last"}, 64'(uop_last), 64'(k == n - 1));
            chk({name, ".pc"}, 64'(uop_pc), 64'(ld && regs[k] == 4'd15));
            chk({name, ".wb_we"}, 64'(wb_we), 64'((k == n - 1) && exp_we));
            if ((k == n - 1) && exp_we) begin
                chk({name, ".wb_wa"}, 64'(wb_wa), 64'(rn));
                chk({name, ".wb_wd"}, 64'(wb_wd), 64'(nb));
            end
            #1;
            chk({name, ".ready_busy"}, 64'(start_ready), 64'd0);
            tick();
            if (!stl) k++;
            cyc++;
        end
        chk({name, ".done"}, 64'(k), 64'(n));
        start = 1'b0;
        stall = 1'b0;
        chk_quiet({name, ".end"});
        cycles = cyc;
    endtask

    initial begin
        // Reset state
        #2;
        chk_quiet("rst");
        chk("rst.last", 64'(uop_last), 64'd0);
        chk("rst.addr", 64'(uop_addr), 64'd0);
        tick();
        #3 reset = 1'b1;
        tick();
        chk("rst.ready", 64'(start_ready), 64'd1);
        chk_quiet("rst.idle");

        // start_ready follows stall; a stalled start is not accepted
        stall = 1'b1; start = 1'b1; reglist = 16'h0003; base_val = 32'h100;
        #1;
        chk("stl.ready", 64'(start_ready), 64'd0);
        tick();
        start = 1'b0; stall = 1'b0;
        chk_quiet("stl.ign");
        tick();
        chk_quiet("stl.ign2");

        run_instr("stm_ia", 1'b0, 1'b0, 1'b1, 1'b1, 16'h002A, 4'd13, 32'h1000, 0, -1, 0, cyc_o);
        run_instr("ldm_db", 1'b1, 1'b1, 1'b0, 1'b0, 16'h8001, 4'd2, 32'h2000, 0, -1, 0, cyc_o);
        run_instr("ldm_ib", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0050, 4'd4, 32'h40, 0, -1, 0, cyc_o);
        run_instr("empty", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'd1, 32'h3000, 0, -1, 0, cyc_o);
        tick();
        chk_quiet("empty.after");
        run_instr("stall", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0111, 4'd13, 32'h5000, 0, 1, 2, cyc_o);
        chk("stall.cycles", 64'(cyc_o), 64'd5);
        run_instr("stm_da", 1'b0, 1'b0, 1'b0, 1'b1, 16'h00F0, 4'd5, 32'h800, 0, -1, 0, cyc_o);

        // Asynchronous reset in the middle of a 4-register LDM with writeback
        start = 1'b1; is_load = 1'b1; pre = 1'b0; up = 1'b1; wback = 1'b1;
        reglist = 16'h0F00; base_rn = 4'd1; base_val = 32'h7000;
        tick();
        start = 1'b0;
        chk("arst.u0", 64'(uop_addr), 64'h7000);
        tick();
        chk("arst.u1", 64'(uop_reg), 64'd9);
        #2 reset = 1'b0;
        #1;
        chk_quiet("arst.now");
        chk("arst.reg", 64'(uop_reg), 64'd0);
        chk("arst.addr", 64'(uop_addr), 64'd0);
        tick();
        chk_quiet("arst.hold");
        #3 reset = 1'b1;
        tick();
        chk_quiet("arst.post");
        tick();
        chk_quiet("arst.post2");
        run_instr("arst.fresh", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0F00, 4'd1, 32'h7000, 0, -1, 0, cyc_o);

        // Randomized instructions with random stalls
        for (int t = 0; t < 60; t++) begin
            logic [15:0] l;
            l = 16'($urandom) & 16'($urandom);
            if (t % 10 == 3) l = 16'h0000;
            if (t % 10 == 7) l = 16'hFFFF;
            run_instr($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), l, 4'($urandom), $urandom, 25, -1, 0, cyc_o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Decode-stage micro-sequencer for block transfers (LDM/STM). Sits directly upstream of the register file.
- Expands one block-transfer instruction into one transfer micro-op per listed register. Each micro-op carries a register index for the regfile port-3 read/write and a word address.
- Drives the regfile second write port (we1/wa1/wd1) for base-register writeback.
- Stalls the fetch/decode front end while it is active.

Parameters:
- NREG, 16, number of architectural registers; width of the register list.
- AW, 32, address/data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  decoded block-transfer instruction valid this cycle.
- is_load  in  1  1 = LDM, 0 = STM.
- pre  in  1  P bit: 1 = increment/decrement before each transfer.
- up  in  1  U bit: 1 = ascending addresses from base, 0 = descending.
- wback  in  1  W bit: write the updated base back.
- reglist  in  NREG  register list; bit i selects Ri.
- base_rn  in  4  base register index.
- base_val  in  AW  base register value, sampled on the accepted start.
- stall  in  1  downstream not ready; freezes the sequencer.
- start_ready  out  1  high when start is accepted (IDLE and not stall).
- busy  out  1  high while an accepted instruction is in progress; front end must stall.
- uop_valid  out  1  transfer micro-op valid.
- uop_reg  out  4  register index for this transfer (regfile ra3/wa3).
- uop_addr  out  AW  word address for this transfer.
- uop_load  out  1  micro-op is a load.
- uop_last  out  1  final transfer of the instruction.
- uop_pc  out  1  load whose destination is R15; downstream must flush.
- wb_we  out  1  base writeback enable (regfile we1).
- wb_wa  out  4  base writeback index (regfile wa1).
- wb_wd  out  AW  base writeback value (regfile wd1).

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - All outputs 0 except start_ready, which is 1 once reset deasserts.
  - Any in-flight instruction is abandoned with no writeback.
- States: IDLE, XFER.
- IDLE:
  - start_ready = ~stall.
  - On start & ~stall, latch: remaining-list = reglist, is_load, base_rn, wback, n = popcount(reglist).
  - Compute first address A0 (wrap mod 2^AW, low 2 address bits forced 0):
    - IA (P=0,U=1): base_val.
    - IB (P=1,U=1): base_val+4.
    - DA (P=0,U=0): base_val-4n+4.
    - DB (P=1,U=0): base_val-4n.
  - Compute new base: U ? base_val+4n : base_val-4n.
  - If n≠0, go to XFER. If reglist==0, accept, stay IDLE, emit nothing, no writeback.
- XFER:
  - Each non-stalled cycle emits one micro-op with uop_valid=1.
  - uop_reg = lowest set bit of the remaining list; uop_addr = current address.
  - Then clear that bit and advance the address by +4. Transfers always go lowest register to lowest address, regardless of U.
  - uop_last=1 when exactly one bit remains; return to IDLE after that cycle.
- Latency:
  - First micro-op appears the cycle after start is accepted.
  - n micro-ops take n consecutive cycles when there is no stall.
  - busy is high from the cycle after acceptance through the last micro-op.
- Writeback:
  - wb_we=1 on the same cycle as uop_last when wback=1, with wb_wa=base_rn and wb_wd=new base.
  - Suppressed (wb_we=0) when is_load=1 and base_rn is in the list; the loaded value wins.
  - For STM with base in the list, the stored value is the regfile's pre-writeback value, since writeback only occurs on the last cycle.
- uop_pc = uop_valid & uop_load & (uop_reg==15).
- stall=1:
  - All outputs and state hold unchanged, including uop_valid and wb_we.
  - Downstream consumes a micro-op only on cycles with stall=0.
- start while busy: ignored (start_ready=0). The decoder must hold the instruction.
- Outputs are registered, with no combinational path from start to uop_*. start_ready is the exception: it is combinational on stall.

Decomposition:
- Shared package holds the addressing-mode encoding constants (IA/IB/DA/DB from {P,U}), the state encoding, and the PC register index (4'd15).
- One natural sub-module: prio_enc16, which returns the lowest-set-bit index and a "one bit left" flag from a 16-bit mask.
- Popcount stays inline.

Test Plan:
- STM IA, base R13=0x1000, list {R1,R3,R5}, W=1:
  - 3 micro-ops: (R1,0x1000), (R3,0x1004), (R5,0x1008).
  - uop_last on the third.
  - wb_we=1, wb_wa=13, wb_wd=0x100C on that cycle.
- LDM DB, base R2=0x2000, list {R0,R15}, W=0:
  - Micro-ops (R0,0x1FF8), (R15,0x1FFC).
  - uop_pc=1 on the second; wb_we stays 0.
- LDM IB, base R4=0x40, list {R4,R6}, W=1: addresses 0x44, 0x48; wb_we stays 0 (base in list on a load).
- Empty list:
  - start with reglist=0 is accepted in 1 cycle.
  - busy, uop_valid and wb_we all stay 0.
- stall held 2 cycles during the second micro-op of a 3-register STM: that micro-op is held unchanged for the stalled cycles; total 5 cycles; addresses unaffected.
- reset pulsed low mid-XFER of a 4-register LDM:
  - Outputs clear immediately (asynchronously) and no writeback occurs.
  - A fresh start after reset deasserts sequences correctly.
